// File: rtl/npc_mem_pkg.sv
// Package npc_mem_pkg
// Shared types for the NPC memory-port arbiter: the transaction FSM states
// and the master IDs that record which requester owns the current transaction.
package npc_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   typedef enum logic {
      MST_IFU = 1'b0,
      MST_LSU = 1'b1
   } mst_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Module mem_arb_picker
// Grant logic for the two memory masters. The grants are purely
// combinational; the top module qualifies them with its IDLE state.
// Optional build macro: MEM_ARB_RR_EN
//   undefined -> fixed priority, LSU wins a tie
//   defined   -> round-robin, a tie goes to the master not granted last
// Ports:
//   clk, rst   core clock, synchronous active-high reset
//   ifu_valid  IFU has a pending request
//   lsu_valid  LSU has a pending request
//   accept     a request is accepted this cycle
//   grant_ifu  IFU would be accepted
//   grant_lsu  LSU would be accepted
module mem_arb_picker
   import npc_mem_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic ifu_valid,
   input  logic lsu_valid,
   input  logic accept,
   output logic grant_ifu,
   output logic grant_lsu
);

`ifdef MEM_ARB_RR_EN
   mst_t last_grant_q;

   // Reset to LSU so that the first tie after reset goes to the IFU.
   always_ff @(posedge clk) begin
      if (rst)
         last_grant_q <= MST_LSU;
      else if (accept)
         last_grant_q <= grant_lsu ? MST_LSU : MST_IFU;
   end

   assign grant_lsu = lsu_valid && (!ifu_valid || last_grant_q == MST_IFU);
   assign grant_ifu = ifu_valid && !grant_lsu;
`else
   // Fixed priority has no state; the clock/reset/accept inputs are unused here.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, clk, rst, accept};

   assign grant_lsu = lsu_valid;
   assign grant_ifu = ifu_valid && !lsu_valid;
`endif

endmodule

// File: rtl/npc_mem_arbiter.sv
// Module npc_mem_arbiter
// Shares the single NPC data-memory port between the IFU (master 0) and the
// LSU (master 1). One transaction is outstanding at a time:
//   IDLE -> REQ -> WAIT -> RESP -> IDLE
// A timeout in WAIT returns an error response if memory never answers.
// Optional build macro: MEM_ARB_RR_EN (round-robin arbitration, see mem_arb_picker).
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   ifu_req_* / ifu_addr          IFU read request channel
//   ifu_rsp_* / ifu_rdata         IFU response channel (err = timeout)
//   lsu_req_* / lsu_addr/wen/...  LSU read/write request channel
//   lsu_rsp_* / lsu_rdata         LSU response channel (rdata = 0 for writes)
//   mem_req_* / mem_addr/wen/...  request to memory, fields held from accept
//   mem_rsp_valid / mem_rdata     one-cycle response pulse from memory
//   busy                          a transaction is in flight
module npc_mem_arbiter
   import npc_mem_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   input  logic                ifu_rsp_ready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic                ifu_rsp_err,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   input  logic                lsu_rsp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_rsp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic                mem_rsp_valid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t              state_q, state_d;
   mst_t                owner_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic                grant_ifu, grant_lsu;
   logic                idle, accept, timeout_hit, owner_rsp_ready;

   assign idle            = (state_q == ST_IDLE);
   assign accept          = idle && (ifu_req_valid || lsu_req_valid);
   assign timeout_hit     = (cnt_q == CNT_LAST);
   assign owner_rsp_ready = (owner_q == MST_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

   mem_arb_picker u_picker (
      .clk       (clk),
      .rst       (rst),
      .ifu_valid (ifu_req_valid),
      .lsu_valid (lsu_req_valid),
      .accept    (accept),
      .grant_ifu (grant_ifu),
      .grant_lsu (grant_lsu)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // NOTE: state_d is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept)                        state_d = ST_REQ;
         ST_REQ:  if (mem_req_ready)                 state_d = ST_WAIT;
         ST_WAIT: if (mem_rsp_valid || timeout_hit)  state_d = ST_RESP;
         ST_RESP: if (owner_rsp_ready)               state_d = ST_IDLE;
         default:                                    state_d = ST_IDLE;
      endcase
   end

   // Request fields, owner, timeout counter and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q   <= MST_IFU;
         mem_addr  <= '0;
         mem_wen   <= 1'b0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (grant_lsu) begin
                     owner_q   <= MST_LSU;
                     mem_addr  <= lsu_addr;
                     mem_wen   <= lsu_wen;
                     mem_wdata <= lsu_wdata;
                     mem_wmask <= lsu_wmask;
                  end else begin
                     owner_q   <= MST_IFU;
                     mem_addr  <= ifu_addr;
                     mem_wen   <= 1'b0;
                     mem_wdata <= '0;
                     mem_wmask <= '0;
                  end
               end
            end
            ST_REQ: begin
               if (mem_req_ready)
                  cnt_q <= '0;
            end
            ST_WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               // A response arriving on the timeout cycle still counts as success.
               if (mem_rsp_valid) begin
                  rdata_q <= mem_wen ? '0 : mem_rdata;
                  err_q   <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ifu_req_ready = idle && grant_ifu;
   assign lsu_req_ready = idle && grant_lsu;
   assign mem_req_valid = (state_q == ST_REQ);
   assign ifu_rsp_valid = (state_q == ST_RESP) && (owner_q == MST_IFU);
   assign lsu_rsp_valid = (state_q == ST_RESP) && (owner_q == MST_LSU);
   assign ifu_rdata     = rdata_q;
   assign lsu_rdata     = rdata_q;
   assign ifu_rsp_err   = err_q;
   assign lsu_rsp_err   = err_q;
   assign busy          = !idle;

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Testbench for npc_mem_arbiter with TIMEOUT_CYCLES = 8.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 1 unit after that, well away from the active edge.
module tb_npc_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   npc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rdata(ifu_rdata),
      .ifu_rsp_err(ifu_rsp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rdata(lsu_rdata),
      .lsu_rsp_err(lsu_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called during the REQ cycle: memory accepts now, answers in the next cycle.
   task automatic serve(input logic [31:0] data);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rdata     = data;
      tick();
      mem_rsp_valid = 1'b0;
      mem_rdata     = 32'h0;
      #1;
   endtask

   task automatic handshake(input logic is_lsu);
      if (is_lsu) lsu_rsp_ready = 1'b1;
      else        ifu_rsp_ready = 1'b1;
      tick();
      ifu_rsp_ready = 1'b0;
      lsu_rsp_ready = 1'b0;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 0;
      lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_rsp_ready = 0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
      do_reset();
      checks++;
      if ({busy, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 000000",
                  {busy, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, ifu_req_ready, lsu_req_ready});
      end
      checks++;
      if ({ifu_rdata, ifu_rsp_err, lsu_rsp_err} !== 34'h0) begin
         errors++;
         $display("FAIL reset_data: got rdata=%h err=%b%b required 0", ifu_rdata, ifu_rsp_err, lsu_rsp_err);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_req: got busy=%b required 0", busy);
      end
   endtask

   task automatic test_ifu_read();
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0000;
      #1;
      checks++;
      if (ifu_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ifu_accept: got ready=%b required 1", ifu_req_ready);
      end
      tick();
      ifu_req_valid = 1'b0;
      ifu_addr      = 32'h0;
      #1;
      checks++;
      if ({mem_req_valid, busy, mem_wen, mem_wmask} !== 7'b1100000 || mem_addr !== 32'h8000_0000) begin
         errors++;
         $display("FAIL ifu_mem_req: got valid=%b busy=%b wen=%b mask=%h addr=%h required 1 1 0 0 80000000",
                  mem_req_valid, busy, mem_wen, mem_wmask, mem_addr);
      end
      serve(32'h0010_0073);
      // Three cycles after the accept cycle: response must be visible.
      checks++;
      if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err} !== 3'b100 || ifu_rdata !== 32'h0010_0073) begin
         errors++;
         $display("FAIL ifu_rsp: got valid=%b lsu_valid=%b err=%b rdata=%h required 1 0 0 00100073",
                  ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, ifu_rdata);
      end
      tick();
      checks++;
      if (ifu_rsp_valid !== 1'b1 || ifu_rdata !== 32'h0010_0073) begin
         errors++;
         $display("FAIL ifu_rsp_hold: got valid=%b rdata=%h required 1 00100073", ifu_rsp_valid, ifu_rdata);
      end
      handshake(1'b0);
      checks++;
      if ({busy, ifu_rsp_valid} !== 2'b00) begin
         errors++;
         $display("FAIL ifu_done: got busy=%b valid=%b required 0 0", busy, ifu_rsp_valid);
      end
   endtask

`ifndef MEM_ARB_RR_EN
   task automatic test_fixed_prio();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0020; lsu_wen = 1'b0;
      #1;
      checks++;
      if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
         errors++;
         $display("FAIL prio_grant: got lsu_ready=%b ifu_ready=%b required 1 0", lsu_req_ready, ifu_req_ready);
      end
      tick();
      lsu_req_valid = 1'b0;
      #1;
      checks++;
      if (mem_addr !== 32'h8000_0020 || ifu_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL prio_lsu_first: got addr=%h ifu_ready=%b required 80000020 0", mem_addr, ifu_req_ready);
      end
      serve(32'h1122_3344);
      checks++;
      if ({lsu_rsp_valid, ifu_rsp_valid, ifu_req_ready} !== 3'b100 || lsu_rdata !== 32'h1122_3344) begin
         errors++;
         $display("FAIL prio_lsu_rsp: got lsu_v=%b ifu_v=%b ifu_ready=%b rdata=%h required 1 0 0 11223344",
                  lsu_rsp_valid, ifu_rsp_valid, ifu_req_ready, lsu_rdata);
      end
      handshake(1'b1);
      checks++;
      if (ifu_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL prio_ifu_next: got ifu_ready=%b required 1", ifu_req_ready);
      end
      tick();
      ifu_req_valid = 1'b0;
      #1;
      checks++;
      if (mem_addr !== 32'h8000_0004 || mem_req_valid !== 1'b1) begin
         errors++;
         $display("FAIL prio_ifu_req: got addr=%h valid=%b required 80000004 1", mem_addr, mem_req_valid);
      end
      serve(32'hA5A5_0001);
      checks++;
      if (ifu_rsp_valid !== 1'b1 || ifu_rdata !== 32'hA5A5_0001) begin
         errors++;
         $display("FAIL prio_ifu_rsp: got valid=%b rdata=%h required 1 a5a50001", ifu_rsp_valid, ifu_rdata);
      end
      handshake(1'b0);
   endtask
`else
   task automatic test_round_robin();
      logic [31:0] exp_addr;
      do_reset();
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         // Expected order IFU, LSU, IFU, LSU.
         exp_addr = (i % 2 == 0) ? 32'h8000_0100 : 32'h8000_0200;
         #1;
         checks++;
         if ({ifu_req_ready, lsu_req_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL rr_grant%0d: got ifu=%b lsu=%b", i, ifu_req_ready, lsu_req_ready);
         end
         tick();
         checks++;
         if (mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL rr_addr%0d: got %h required %h", i, mem_addr, exp_addr);
         end
         serve(32'h100 + i);
         handshake(i % 2 == 1);
      end
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
   endtask
`endif

   task automatic test_write();
      lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0010;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
      #1;
      checks++;
      if (lsu_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr_accept: got ready=%b required 1", lsu_req_ready);
      end
      tick();
      lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
      #1;
      checks++;
      if (mem_addr !== 32'h8000_0010 || mem_wen !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF) begin
         errors++;
         $display("FAIL wr_fields: got addr=%h wen=%b wdata=%h mask=%h required 80000010 1 deadbeef f",
                  mem_addr, mem_wen, mem_wdata, mem_wmask);
      end
      serve(32'hCAFE_F00D);
      checks++;
      if (lsu_rsp_valid !== 1'b1 || lsu_rdata !== 32'h0 || lsu_rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL wr_rsp: got valid=%b rdata=%h err=%b required 1 0 0", lsu_rsp_valid, lsu_rdata, lsu_rsp_err);
      end
      handshake(1'b1);
   endtask

   // Runs an LSU read up to the 8th WAIT cycle; the caller decides the last cycle.
   task automatic lsu_read_to_last_wait(input logic [31:0] addr);
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = addr;
      tick();
      lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      repeat (7) tick();
   endtask

   task automatic test_timeout();
      lsu_read_to_last_wait(32'h8000_0030);
      checks++;
      if (lsu_rsp_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL to_early: got valid=%b busy=%b required 0 1", lsu_rsp_valid, busy);
      end
      tick();
      checks++;
      if (lsu_rsp_valid !== 1'b1 || lsu_rsp_err !== 1'b1 || lsu_rdata !== 32'h0) begin
         errors++;
         $display("FAIL to_err: got valid=%b err=%b rdata=%h required 1 1 0", lsu_rsp_valid, lsu_rsp_err, lsu_rdata);
      end
      mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0055;
      tick();
      mem_rsp_valid = 1'b0; mem_rdata = 0;
      #1;
      checks++;
      if (lsu_rsp_valid !== 1'b1 || lsu_rsp_err !== 1'b1 || lsu_rdata !== 32'h0) begin
         errors++;
         $display("FAIL to_late_rsp: got valid=%b err=%b rdata=%h required 1 1 0", lsu_rsp_valid, lsu_rsp_err, lsu_rdata);
      end
      handshake(1'b1);
      mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0066;
      tick();
      mem_rsp_valid = 1'b0; mem_rdata = 0;
      #1;
      checks++;
      if ({busy, mem_req_valid, lsu_rsp_valid, ifu_rsp_valid} !== 4'b0) begin
         errors++;
         $display("FAIL stray_rsp: got busy=%b req=%b lsu_v=%b ifu_v=%b required 0",
                  busy, mem_req_valid, lsu_rsp_valid, ifu_rsp_valid);
      end
   endtask

   task automatic test_rsp_at_timeout();
      lsu_read_to_last_wait(32'h8000_0040);
      mem_rsp_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_rsp_valid = 1'b0; mem_rdata = 0;
      #1;
      checks++;
      if (lsu_rsp_valid !== 1'b1 || lsu_rsp_err !== 1'b0 || lsu_rdata !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL rsp_wins: got valid=%b err=%b rdata=%h required 1 0 0badf00d",
                  lsu_rsp_valid, lsu_rsp_err, lsu_rdata);
      end
      handshake(1'b1);
   endtask

   task automatic test_reset_mid();
      lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0050;
      tick();
      lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, mem_req_valid, lsu_rsp_valid, ifu_rsp_valid} !== 4'b0 || lsu_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b req=%b lsu_v=%b ifu_v=%b rdata=%h required all 0",
                  busy, mem_req_valid, lsu_rsp_valid, ifu_rsp_valid, lsu_rdata);
      end
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_ifu_read();
`ifdef MEM_ARB_RR_EN
      test_round_robin();
`else
      test_fixed_prio();
`endif
      test_write();
      test_timeout();
      test_rsp_at_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
